dest_sel_pipe: RTL

Parametrised destination-register selector with pipeline tracking for the RISC core.
- Extracts the write-destination field from the decoded instruction, using a configurable field set.
- Carries the destination through a configurable number of pipeline stages, with stall and flush.
- Reports per-stage matches against two source operands, so the hazard/forwarding logic can use one block instead of per-stage comparators.

---
 rtl/dest_sel_pipe_if.sv | 35 +++
 rtl/dest_sel_pipe.sv | 97 +++++++++
 2 files changed

// File: rtl/dest_sel_pipe_if.sv
// Bundles the decode, pipeline-control and hazard signals of dest_sel_pipe.
// Master drives the instruction and control side; slave is the tracker itself.
interface dest_sel_pipe_if #(
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned REG_AW  = 3,
   parameter int unsigned SEL_W   = 2,
   parameter int unsigned DEPTH   = 3
);
   logic [INSTR_W-1:0]      instr_in;
   logic                    instr_valid;
   logic                    reg_write;
   logic [SEL_W-1:0]        reg_destsel;
   logic                    stall;
   logic                    flush;
   logic [REG_AW-1:0]       src_a;
   logic [REG_AW-1:0]       src_b;
   logic [REG_AW-1:0]       wb_dest;
   logic                    wb_valid;
   logic [DEPTH*REG_AW-1:0] stage_dest;
   logic [DEPTH-1:0]        stage_valid;
   logic [DEPTH-1:0]        match_a;
   logic [DEPTH-1:0]        match_b;
   logic                    hazard_a;
   logic                    hazard_b;

   modport master (
      output instr_in, instr_valid, reg_write, reg_destsel, stall, flush, src_a, src_b,
      input  wb_dest, wb_valid, stage_dest, stage_valid, match_a, match_b, hazard_a, hazard_b
   );

   modport slave (
      input  instr_in, instr_valid, reg_write, reg_destsel, stall, flush, src_a, src_b,
      output wb_dest, wb_valid, stage_dest, stage_valid, match_a, match_b, hazard_a, hazard_b
   );
endinterface

// File: rtl/dest_sel_pipe.sv
// Destination-register selector with per-stage tracking and source-match reporting.
// Optional macro DEST_ZERO_REG_EN: register 0 is hardwired zero and never tracked or matched.
module dest_sel_pipe #(
   parameter int unsigned INSTR_W    = 16,
   parameter int unsigned REG_AW     = 3,
   parameter int unsigned NUM_FIELDS = 3,
   parameter int unsigned SEL_W      = 2,
   parameter int unsigned FIELD0_LSB = 9,
   parameter int unsigned FIELD1_LSB = 6,
   parameter int unsigned FIELD2_LSB = 3,
   parameter int unsigned DEPTH      = 3
) (
   input  logic             clk,
   input  logic             rst,
   dest_sel_pipe_if.slave   bus
);

   logic [REG_AW-1:0] dec_dest;
   logic              dec_ok;
   logic [REG_AW-1:0] entry_dest;
   logic              entry_valid;
   logic [REG_AW-1:0] dest_q [DEPTH];
   logic [DEPTH-1:0]  valid_q;

   // Field decode; selects beyond the configured set mean "no destination".
   always_comb begin
      dec_dest = '0;
      dec_ok   = 1'b0;
      if (32'(bus.reg_destsel) < NUM_FIELDS) begin
         if (32'(bus.reg_destsel) == 32'd0) begin
            dec_dest = bus.instr_in[FIELD0_LSB +: REG_AW];
            dec_ok   = 1'b1;
         end else if (32'(bus.reg_destsel) == 32'd1) begin
            dec_dest = bus.instr_in[FIELD1_LSB +: REG_AW];
            dec_ok   = 1'b1;
         end else if (32'(bus.reg_destsel) == 32'd2) begin
            dec_dest = bus.instr_in[FIELD2_LSB +: REG_AW];
            dec_ok   = 1'b1;
         end
      end
   end

   // Stage-0 entry; an invalid entry always carries dest 0.
   always_comb begin
      entry_valid = bus.instr_valid & bus.reg_write & dec_ok;
`ifdef DEST_ZERO_REG_EN
      entry_valid = entry_valid & (dec_dest != '0);
`endif
      entry_dest  = entry_valid ? dec_dest : '0;
   end

   // Stage shift register with stall hold and flush that lets the oldest survivor retire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) dest_q[k] <= '0;
         valid_q <= '0;
      end else if (bus.flush) begin
         for (int k = 0; k < DEPTH - 1; k++) dest_q[k] <= '0;
         valid_q[DEPTH-2:0] <= '0;
         dest_q[DEPTH-1]    <= dest_q[DEPTH-2];
         valid_q[DEPTH-1]   <= valid_q[DEPTH-2];
      end else if (!bus.stall) begin
         dest_q[0]  <= entry_dest;
         valid_q[0] <= entry_valid;
         for (int k = 1; k < DEPTH; k++) begin
            dest_q[k]  <= dest_q[k-1];
            valid_q[k] <= valid_q[k-1];
         end
      end
   end

   // Flatten stage state onto the output bus.
   always_comb begin
      bus.stage_dest = '0;
      for (int k = 0; k < DEPTH; k++) bus.stage_dest[k*REG_AW +: REG_AW] = dest_q[k];
      bus.stage_valid = valid_q;
      bus.wb_dest     = dest_q[DEPTH-1];
      bus.wb_valid    = valid_q[DEPTH-1];
   end

   // Per-stage source comparison; invalid stages never match their stale zero.
   always_comb begin
      bus.match_a = '0;
      bus.match_b = '0;
      for (int k = 0; k < DEPTH; k++) begin
         bus.match_a[k] = valid_q[k] && (dest_q[k] == bus.src_a);
         bus.match_b[k] = valid_q[k] && (dest_q[k] == bus.src_b);
      end
`ifdef DEST_ZERO_REG_EN
      if (bus.src_a == '0) bus.match_a = '0;
      if (bus.src_b == '0) bus.match_b = '0;
`endif
      bus.hazard_a = |bus.match_a;
      bus.hazard_b = |bus.match_b;
   end

endmodule
